// File: rtl/fetch_unit_if.sv
// rtl/fetch_unit_if.sv - fetch unit bus bundle (imem request/response, instr stream, redirect)
//
// Purpose: groups every handshake signal of the fetch stage so the stage and
// its environment connect through one port.
//
// Signals:
//   imem_req/imem_addr      fetch request and word-aligned address
//   imem_gnt                request accepted this cycle
//   imem_rvalid/imem_rdata  in-order response from instruction memory
//   instr_valid/instr_ready instruction stream handshake toward the core
//   instr/instr_pc          instruction word and its PC
//   redirect/redirect_pc    one-cycle flush pulse and restart PC
//
// Modports:
//   master  fetch unit side
//   slave   memory + core side
interface fetch_unit_if #(
  parameter int N = 32
);
  logic         imem_req;
  logic [N-1:0] imem_addr;
  logic         imem_gnt;
  logic         imem_rvalid;
  logic [N-1:0] imem_rdata;
  logic         instr_valid;
  logic         instr_ready;
  logic [N-1:0] instr;
  logic [N-1:0] instr_pc;
  logic         redirect;
  logic [N-1:0] redirect_pc;

  modport master (
    output imem_req, imem_addr,
    input  imem_gnt, imem_rvalid, imem_rdata,
    output instr_valid, instr, instr_pc,
    input  instr_ready,
    input  redirect, redirect_pc
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_gnt, imem_rvalid, imem_rdata,
    input  instr_valid, instr, instr_pc,
    output instr_ready,
    output redirect, redirect_pc
  );
endinterface

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage with credit-limited prefetch FIFO
//
// Purpose: issues word-aligned fetch addresses over a req/gnt/rvalid protocol,
// buffers returned words with their PCs in a DEPTH-entry FIFO and presents
// them to the core over valid/ready. A redirect flushes the FIFO and marks
// every response still in flight as to-be-discarded.
//
// Ports:
//   clk   in   rising-edge clock
//   rst   in   asynchronous active-low reset
//   bus   fetch_unit_if.master (imem_*, instr_*, redirect*)
//
// Parameters:
//   N         data/address width
//   DEPTH     FIFO entries and maximum outstanding requests (power of two, >= 2)
//   RESET_PC  first fetch address after reset (word-aligned)
//
// Build option:
//   FETCH_BYPASS_EN  when defined, a response arriving while the FIFO is empty
//                    (state RUN, no redirect) is forwarded combinationally to
//                    instr/instr_pc in the same cycle. Undefined: outputs come
//                    only from the FIFO head, one cycle minimum latency.
module fetch_unit #(
  parameter int           N        = 32,
  parameter int           DEPTH    = 4,
  parameter logic [N-1:0] RESET_PC = '0
) (
  input logic          clk,
  input logic          rst,
  fetch_unit_if.master bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic {
    S_RUN   = 1'b0,
    S_FLUSH = 1'b1
  } state_t;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_t        r_state;
  logic [N-1:0]  r_fetch_pc;
  logic [N-1:0]  r_resp_pc;
  logic [CW-1:0] r_outstanding;
  logic [CW-1:0] r_discard;
  logic [CW-1:0] r_occ;
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [N-1:0]  r_fifo_data [DEPTH];
  logic [N-1:0]  r_fifo_pc   [DEPTH];

  // ---------------------------------------------------------------------------
  // Combinational signals
  // ---------------------------------------------------------------------------
  state_t        w_state_nxt;
  logic [CW-1:0] w_outstanding_nxt;
  logic [CW-1:0] w_discard_nxt;
  logic [CW-1:0] w_occ_nxt;
  logic [CW:0]   w_credit_sum;
  logic          w_req;
  logic          w_grant;
  logic          w_fifo_empty;
  logic          w_rv;
  logic          w_rv_run;
  logic          w_rv_flush;
  logic          w_bypass;
  logic          w_push;
  logic          w_pop;
  logic [N-1:0]  w_redirect_pc;

  assign w_redirect_pc = {bus.redirect_pc[N-1:2], 2'b00};
  assign w_fifo_empty  = (r_occ == '0);

  // Every FIFO slot is reserved either by a buffered word, a live request or
  // a request whose response is still to be thrown away. Registered values
  // only, so a pop frees its slot one cycle later.
  assign w_credit_sum = {1'b0, r_occ} + {1'b0, r_outstanding} + {1'b0, r_discard};

  // Gated with rst so the request is low while reset is held even though the
  // counters already read zero.
  assign w_req   = rst && (w_credit_sum < (CW+1)'(DEPTH));
  assign w_grant = w_req && bus.imem_gnt;

  // Responses return in order, so in FLUSH the oldest responses are the ones
  // being discarded. An rvalid with nothing in flight is a protocol error and
  // is ignored entirely.
  assign w_rv       = bus.imem_rvalid &&
                      ((r_state == S_FLUSH) ? (r_discard != '0) : (r_outstanding != '0));
  assign w_rv_run   = w_rv && (r_state == S_RUN);
  assign w_rv_flush = w_rv && (r_state == S_FLUSH);

`ifdef FETCH_BYPASS_EN
  assign w_bypass = w_fifo_empty && w_rv_run && !bus.redirect;
`else
  assign w_bypass = 1'b0;
`endif

  // A bypassed word that the core takes immediately never enters the FIFO.
  assign w_push = w_rv_run && !bus.redirect && !(w_bypass && bus.instr_ready);
  assign w_pop  = !w_fifo_empty && bus.instr_ready;

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign bus.imem_req    = w_req;
  assign bus.imem_addr   = r_fetch_pc;
  assign bus.instr_valid = !w_fifo_empty || w_bypass;
  assign bus.instr       = w_bypass ? bus.imem_rdata : r_fifo_data[r_rptr];
  assign bus.instr_pc    = w_bypass ? r_resp_pc      : r_fifo_pc[r_rptr];

  // ---------------------------------------------------------------------------
  // FSM next state and counter updates
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_nxt       = r_state;
    w_outstanding_nxt = r_outstanding + CW'(w_grant) - CW'(w_rv_run);
    w_discard_nxt     = r_discard - CW'(w_rv_flush);
    w_occ_nxt         = r_occ + CW'(w_push) - CW'(w_pop);

    if (bus.redirect) begin
      // Everything in flight, including a request granted this cycle, must
      // be drained; a response arriving this cycle is already accounted for.
      w_discard_nxt     = r_discard + r_outstanding + CW'(w_grant) - CW'(w_rv);
      w_outstanding_nxt = '0;
      w_occ_nxt         = '0;
      w_state_nxt       = (w_discard_nxt != '0) ? S_FLUSH : S_RUN;
    end else if (r_state == S_FLUSH && w_rv_flush && r_discard == CW'(1)) begin
      w_state_nxt = S_RUN;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Counters and PCs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_outstanding <= '0;
      r_discard     <= '0;
      r_occ         <= '0;
      r_fetch_pc    <= RESET_PC;
      r_resp_pc     <= RESET_PC;
      r_wptr        <= '0;
      r_rptr        <= '0;
    end else begin
      r_outstanding <= w_outstanding_nxt;
      r_discard     <= w_discard_nxt;
      r_occ         <= w_occ_nxt;

      if (bus.redirect) begin
        r_fetch_pc <= w_redirect_pc;
        r_resp_pc  <= w_redirect_pc;
        r_wptr     <= '0;
        r_rptr     <= '0;
      end else begin
        if (w_grant) begin
          r_fetch_pc <= r_fetch_pc + N'(4);
        end
        // Advances for every accepted response, bypassed or buffered.
        if (w_rv_run) begin
          r_resp_pc <= r_resp_pc + N'(4);
        end
        if (w_push) begin
          r_wptr <= r_wptr + AW'(1);
        end
        if (w_pop) begin
          r_rptr <= r_rptr + AW'(1);
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // FIFO storage
  // ---------------------------------------------------------------------------
  // Cleared on reset so instr/instr_pc read zero until the first push.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_fifo_data[i] <= '0;
        r_fifo_pc[i]   <= '0;
      end
    end else if (w_push) begin
      r_fifo_data[r_wptr] <= bus.imem_rdata;
      r_fifo_pc[r_wptr]   <= r_resp_pc;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed self-checking bench for fetch_unit
module tb_fetch_unit;

  localparam int N = 32;

  logic clk = 1'b0;
  logic rst = 1'b0;

  always #5 clk = ~clk;

  fetch_unit_if #(.N(N)) bus ();

  fetch_unit #(
    .N        (N),
    .DEPTH    (4),
    .RESET_PC (32'h0)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  int n_checks = 0;
  int n_fail   = 0;

  bit gnt_en;
  bit rv_en;
  bit ready;

  logic [31:0] mem_q[$];
  logic [31:0] gnt_log[$];
  logic [31:0] pop_pc[$];
  logic [31:0] pop_data[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction

  function automatic logic [31:0] qget(input logic [31:0] q[$], input int i);
    if (i < q.size()) return q[i];
    return 32'hDEAD_BEEF;
  endfunction

  // One clock cycle, entered and left at a falling edge. The memory answers
  // each grant exactly one cycle later (if rv_en), in order.
  task automatic step(input bit redir = 1'b0, input logic [31:0] rpc = 32'h0);
    if (rv_en && mem_q.size() > 0) begin
      bus.imem_rvalid = 1'b1;
      bus.imem_rdata  = mem_word(mem_q.pop_front());
    end else begin
      bus.imem_rvalid = 1'b0;
      bus.imem_rdata  = '0;
    end
    bus.imem_gnt    = gnt_en;
    bus.instr_ready = ready;
    bus.redirect    = redir;
    bus.redirect_pc = rpc;
    #1;
    if (bus.imem_req && bus.imem_gnt) begin
      mem_q.push_back(bus.imem_addr);
      gnt_log.push_back(bus.imem_addr);
    end
    if (bus.instr_valid && bus.instr_ready) begin
      pop_pc.push_back(bus.instr_pc);
      pop_data.push_back(bus.instr);
    end
    @(negedge clk);
    bus.redirect = 1'b0;
  endtask

  task automatic clear_logs();
    mem_q.delete();
    gnt_log.delete();
    pop_pc.delete();
    pop_data.delete();
  endtask

  task automatic do_reset();
    rst             = 1'b0;
    bus.imem_gnt    = 1'b0;
    bus.imem_rvalid = 1'b0;
    bus.imem_rdata  = '0;
    bus.instr_ready = 1'b0;
    bus.redirect    = 1'b0;
    bus.redirect_pc = '0;
    clear_logs();
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    // ---------------- Test 1: reset values, streaming fetch ----------------
    bus.imem_gnt    = 1'b0;
    bus.imem_rvalid = 1'b0;
    bus.imem_rdata  = '0;
    bus.instr_ready = 1'b0;
    bus.redirect    = 1'b0;
    bus.redirect_pc = '0;
    repeat (2) @(negedge clk);
    check("rst_req",   32'(bus.imem_req),    32'h0);
    check("rst_valid", 32'(bus.instr_valid), 32'h0);
    check("rst_instr", bus.instr,            32'h0);
    check("rst_pc",    bus.instr_pc,         32'h0);
    check("rst_addr",  bus.imem_addr,        32'h0);
    rst = 1'b1;
    #1;
    check("rel_req",  32'(bus.imem_req), 32'h1);
    check("rel_addr", bus.imem_addr,     32'h0);
    gnt_en = 1; rv_en = 1; ready = 1;
    step();
    check("t1_lat_c1", 32'(bus.instr_valid), 32'h0);
    step();
    check("t1_lat_c2", 32'(bus.instr_valid), 32'h1);
    check("t1_lat_pc", bus.instr_pc,         32'h0);
    step();
    check("t1_ngnt", gnt_log.size(),   32'd3);
    check("t1_g0",   qget(gnt_log, 0), 32'h0);
    check("t1_g1",   qget(gnt_log, 1), 32'h4);
    check("t1_g2",   qget(gnt_log, 2), 32'h8);
    repeat (5) step();
    for (int i = 0; i < 3; i++) begin
      check($sformatf("t1_pc%0d", i),   qget(pop_pc, i),   32'(4 * i));
      check($sformatf("t1_data%0d", i), qget(pop_data, i), mem_word(32'(4 * i)));
    end

    // ---------------- Test 2: credit limit with core stalled ----------------
    do_reset();
    gnt_en = 1; rv_en = 1; ready = 0;
    repeat (10) step();
    check("t2_ngnt",  gnt_log.size(),       32'd4);
    check("t2_req",   32'(bus.imem_req),    32'h0);
    check("t2_occ",   32'(dut.r_occ),       32'd4);
    check("t2_valid", 32'(bus.instr_valid), 32'h1);
    check("t2_head",  bus.instr_pc,         32'h0);
    ready = 1;
    step();
    check("t2_credit", 32'(bus.imem_req), 32'h1);
    repeat (8) step();
    for (int i = 0; i < 4; i++) begin
      check($sformatf("t2_pc%0d", i),   qget(pop_pc, i),   32'(4 * i));
      check($sformatf("t2_data%0d", i), qget(pop_data, i), mem_word(32'(4 * i)));
    end
    check("t2_resume", qget(gnt_log, 4), 32'h10);

    // ---------------- Test 3: redirect with 3 outstanding ----------------
    do_reset();
    gnt_en = 1; rv_en = 0; ready = 1;
    repeat (3) step();
    check("t3_out", 32'(dut.r_outstanding), 32'd3);
    gnt_en = 0;
    step(1'b1, 32'h103);
    check("t3_addr", bus.imem_addr,          32'h100);
    check("t3_disc", 32'(dut.r_discard),     32'd3);
    check("t3_out0", 32'(dut.r_outstanding), 32'd0);
    check("t3_req",  32'(bus.imem_req),      32'h1);
    gnt_en = 1; rv_en = 1;
    repeat (12) step();
    check("t3_pc0",   qget(pop_pc, 0),   32'h100);
    check("t3_data0", qget(pop_data, 0), mem_word(32'h100));
    check("t3_pc1",   qget(pop_pc, 1),   32'h104);

    // ---------------- Test 4: redirect with gnt and rvalid together ----------------
    do_reset();
    gnt_en = 1; rv_en = 1; ready = 1;
    step();
    step(1'b1, 32'h200);
    check("t4_disc",  32'(dut.r_discard),     32'd1);
    check("t4_state", 32'(dut.r_state),       32'd1);
    check("t4_addr",  bus.imem_addr,          32'h200);
    check("t4_out",   32'(dut.r_outstanding), 32'd0);
    repeat (8) step();
    check("t4_pc0",   qget(pop_pc, 0),   32'h200);
    check("t4_data0", qget(pop_data, 0), mem_word(32'h200));
    check("t4_pc1",   qget(pop_pc, 1),   32'h204);

    // ---------------- Test 5: grant withheld ----------------
    do_reset();
    gnt_en = 0; rv_en = 1; ready = 1;
    for (int i = 0; i < 5; i++) begin
      step();
      check($sformatf("t5_req%0d", i),  32'(bus.imem_req), 32'h1);
      check($sformatf("t5_addr%0d", i), bus.imem_addr,     32'h0);
    end
    check("t5_ngnt", gnt_log.size(),         32'd0);
    check("t5_out",  32'(dut.r_outstanding), 32'd0);
    gnt_en = 1;
    step();
    check("t5_g0",    qget(gnt_log, 0), 32'h0);
    check("t5_addr4", bus.imem_addr,    32'h4);

    // ---------------- Test 6: async reset mid-transaction ----------------
    do_reset();
    ready = 0;
    gnt_en = 1; rv_en = 0; step(); step();
    gnt_en = 0; rv_en = 1; step(); step();
    gnt_en = 1; rv_en = 0; step(); step();
    check("t6_occ", 32'(dut.r_occ),         32'd2);
    check("t6_out", 32'(dut.r_outstanding), 32'd2);
    #2 rst = 1'b0;
    #1;
    check("t6_valid", 32'(bus.instr_valid), 32'h0);
    check("t6_req",   32'(bus.imem_req),    32'h0);
    check("t6_pc",    bus.instr_pc,         32'h0);
    @(negedge clk);
    clear_logs();
    mem_q.push_back(32'hC);  // late response from before reset
    gnt_en = 1; rv_en = 1; ready = 1;
    rst = 1'b1;
    #1;
    check("t6_rel_addr", bus.imem_addr, 32'h0);
    repeat (8) step();
    check("t6_pc0",   qget(pop_pc, 0),   32'h0);
    check("t6_data0", qget(pop_data, 0), mem_word(32'h0));
    check("t6_pc1",   qget(pop_pc, 1),   32'h4);
    check("t6_data1", qget(pop_data, 1), mem_word(32'h4));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch stage directly upstream of the core's decode/execute datapath.
- Generates word-aligned fetch addresses and issues them to instruction memory over a req/gnt/rvalid handshake.
- Buffers returned words with their PCs in a small prefetch FIFO and presents them to the core over a valid/ready interface.
- Core-side redirects (taken branch, jal, jalr) flush the buffer and discard responses already in flight.

Parameters:
- N, 32, data/address width.
- DEPTH, 4, prefetch FIFO entries and maximum outstanding requests; power of two, >= 2.
- RESET_PC, 0, first fetch address after reset; word-aligned.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- imem_req  out  1  fetch request valid.
- imem_addr  out  N  fetch address, bits [1:0] always 0.
- imem_gnt  in  1  request accepted this cycle (when imem_req=1).
- imem_rvalid  in  1  response data valid; responses return in order, at least 1 cycle after gnt.
- imem_rdata  in  N  response instruction word.
- instr_valid  out  1  instr/instr_pc valid.
- instr_ready  in  1  core accepts instr this cycle.
- instr  out  N  instruction word.
- instr_pc  out  N  PC of instr.
- redirect  in  1  one-cycle pulse: flush and restart fetch at redirect_pc.
- redirect_pc  in  N  new PC; bits [1:0] ignored (treated as 0).

Behaviour:
- Reset (rst=0, async):
  - fetch_pc=RESET_PC, resp_pc=RESET_PC.
  - FIFO empty; outstanding=0; discard=0; state=RUN.
  - imem_req=0, instr_valid=0, instr=0, instr_pc=0, imem_addr=RESET_PC.
- First cycle after release: imem_req=1, imem_addr=RESET_PC.
- Registers and widths:
  - Counters outstanding, discard and occupancy are $clog2(DEPTH)+1 bits.
  - fetch_pc and resp_pc are N bits, wrap modulo 2^N.
- Credit rule: imem_req = (occupancy + outstanding < DEPTH), using registered values only. Pops free credit the following cycle.
- imem_addr = fetch_pc.
- Grant: on imem_req & imem_gnt, outstanding++ and fetch_pc += 4.
- Ungranted request: may be withdrawn or retargeted freely; memory commits only on gnt.
- Response, state RUN: on imem_rvalid, outstanding--, push {imem_rdata, resp_pc}, resp_pc += 4.
  - imem_rvalid while outstanding=0 is a protocol error; it is ignored.
- Output: instr_valid = FIFO non-empty; instr/instr_pc = head entry, registered. Pop on instr_valid & instr_ready.
  - Fetch-to-instr latency: 1 cycle after rvalid when the FIFO is empty (see option).
- Push and pop in the same cycle: both occur; occupancy unchanged.
- The credit rule guarantees no push to a full FIFO.
- Redirect (redirect=1):
  - FIFO flushed next cycle; a handshake completing in the same cycle still counts as consumed.
  - fetch_pc = resp_pc = {redirect_pc[N-1:2],2'b00}.
  - discard = outstanding + (grant this cycle) - (rvalid this cycle); the rvalid word arriving this cycle is dropped.
  - outstanding is set to 0 for credit purposes; discard is added into the credit check.
  - If discard>0, next state=FLUSH, else RUN.
  - imem_req may assert in the cycle after redirect, subject to credit.
- FLUSH:
  - Each rvalid decrements discard, the data is dropped, and no push occurs.
  - At discard==1 with rvalid, next state=RUN.
  - Grants issued during FLUSH increment outstanding as normal; their responses arrive after the discarded ones.
- Redirect during FLUSH: discard accumulates the current outstanding count; the state remains FLUSH.
- Back-to-back redirects: the last one wins.
- Reset mid-transaction: all state cleared immediately. Late rvalid after reset release counts as a protocol error and is ignored, since outstanding=0.

Optional Feature:
- Macro: FETCH_BYPASS_EN.
- Defined:
  - When the FIFO is empty, state=RUN, no redirect and imem_rvalid=1, the response appears combinationally on instr/instr_pc with instr_valid=1 in the same cycle.
  - If instr_ready=1 it is consumed without a push; otherwise it is pushed.
  - Zero-cycle fetch-to-instr latency.
- Undefined: outputs are purely registered, with 1-cycle minimum latency.

Test Plan:
- Reset release, gnt tied 1, rvalid 1 cycle after gnt, instr_ready=1 -> addresses 0x0,0x4,0x8 issued on consecutive cycles; instr_pc 0x0,0x4,0x8 in order with matching rdata.
- instr_ready=0, memory always grants -> exactly DEPTH=4 grants, then imem_req=0; occupancy=4. Raise instr_ready -> 4 pops, requests resume at 0x10.
- 3 requests outstanding, redirect to 0x103 -> next imem_addr=0x100; the 3 late responses dropped; first instr_pc after redirect = 0x100.
- Redirect in the same cycle as gnt and rvalid -> that rvalid is dropped; the granted request is discarded later; discard = outstanding+1-1.
- imem_gnt held 0 for 5 cycles -> imem_req stays 1 with imem_addr stable; no outstanding increment.
- Async rst asserted with 2 outstanding and FIFO at 2 -> instr_valid=0 and imem_req=0 immediately; after release, fetch restarts at RESET_PC with no stale instr.
